pll_reset_sequencer: RTL and testbench
======================================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16, meaning clk cycles pll_rst is held high per PLL reset pulse (minimum 1).
REQ-002 SHALL have parameter STABLE_CYCLES, default 1024, meaning consecutive synchronized-lock-high cycles required before releasing system reset (minimum 1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning maximum cycles spent in WAIT_LOCK before a retry (must exceed STABLE_CYCLES).
REQ-004 SHALL have parameter MAX_RETRIES, default 7, meaning number of WAIT_LOCK timeouts tolerated before FAIL (1..15).
REQ-005 SHALL have port clk  input  1  free-running init/reference clock; sole clock of the block.
REQ-006 SHALL have port reset  input  1  synchronous, active-high block reset.
REQ-007 SHALL have port pll_lock  input  1  raw PLL lock, asynchronous to clk.
REQ-008 SHALL have port pll_rst  output  1  active-high reset to the PLL.
REQ-009 SHALL have port sys_reset  output  1  active-high reset to downstream logic.
REQ-010 SHALL have port ready  output  1  high only in RUN.
REQ-011 SHALL have port fail  output  1  high only in FAIL.
REQ-012 SHALL have port retry_count  output  4  WAIT_LOCK timeouts since last reset, saturating at 15.

Function
REQ-013 SHALL pass pll_lock through a 2-flop synchronizer (lock_s); all decisions use lock_s only.
REQ-014 SHALL implement states PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL; one cycle counter shared by all states, cleared on every transition, width = clog2 of largest cycle parameter plus 1.
REQ-015 PLL_RST: pll_rst=1, sys_reset=1; after exactly PLL_RST_CYCLES cycles -> WAIT_LOCK.
REQ-016 WAIT_LOCK: pll_rst=0, sys_reset=1; lock_s=1 -> STABLE; counter reaching TIMEOUT_CYCLES with lock_s=0 -> increment retry_count, then PLL_RST if new retry_count <= MAX_RETRIES, else FAIL.
REQ-017 STABLE: lock_s=0 on any cycle -> WAIT_LOCK (timeout counter restarts, retry_count unchanged); lock_s=1 for STABLE_CYCLES consecutive cycles -> RUN.
REQ-018 RUN: sys_reset=0, ready=1; lock_s=0 -> PLL_RST with sys_reset asserted in the same registered update (<=3 clk after pll_lock falls); retry_count unchanged.
REQ-019 FAIL: pll_rst=1, sys_reset=1, fail=1; exits only via reset.
REQ-020 Simultaneous timeout and lock_s rise in WAIT_LOCK: lock wins (-> STABLE, no retry counted).
REQ-021 All outputs SHALL be registered; no combinational path from pll_lock to any output.
REQ-022 Lock glitch shorter than one clk period may be missed; glitches of >=2 cycles in STABLE/RUN SHALL be acted upon.

Reset
REQ-023 On reset=1 at a clk edge: state=PLL_RST, counter=0, retry_count=0, synchronizer flops=0, pll_rst=1, sys_reset=1, ready=0, fail=0.
REQ-024 Reset asserted mid-operation (any state, including RUN and FAIL) SHALL take effect on the next edge and restart the full sequence.

Structure
REQ-025 State encoding typedef and default parameter values SHALL live in the shared board package.
REQ-026 The 2-flop synchronizer SHALL be a sub-module named sync_2ff, reusable elsewhere.
REQ-027 Block SHALL sit between the PLL lock output and all downstream reset consumers; pll_rst drives the PLL reset input directly.

Verification (PLL_RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32, MAX_RETRIES=2)
REQ-028 Normal bring-up: reset 1 cycle, pll_lock rises 10 cycles later -> pll_rst high 4 cycles, ready and sys_reset=0 exactly 2+8 cycles after pll_lock rise edge lands in WAIT_LOCK/STABLE, retry_count=0.
REQ-029 Lock bounce: pll_lock high 5 cycles, low 3, then high -> returns to WAIT_LOCK, RUN reached only after 8 further stable cycles, retry_count=0.
REQ-030 Never locks: pll_lock held 0 -> three PLL_RST pulses total, retry_count 1 then 2 then 3, fail=1 after third timeout, pll_rst and sys_reset stay 1.
REQ-031 Loss in RUN: pll_lock drops for 4 cycles -> sys_reset=1, ready=0 within 3 cycles, new 4-cycle pll_rst pulse, RUN re-entered after re-lock + 8 cycles.
REQ-032 Reset from FAIL: assert reset in FAIL -> fail=0, retry_count=0, pll_rst pulse restarts next cycle.
REQ-033 Race: pll_lock synchronized high on the exact timeout cycle -> STABLE entered, retry_count unchanged.

Source files
------------

// File: rtl/pll_reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer_pkg
// Purpose  : Shared board-level definitions for the PLL reset sequencer:
//            default timing parameters, sequencer state encoding, the
//            registered output bundle and helper functions.
// Revision : 1.0 - initial release
// ============================================================================
package pll_reset_sequencer_pkg;

    // Default timing, in reference-clock cycles.
    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_TIMEOUT_CYCLES = 50000;
    localparam int DEF_MAX_RETRIES    = 7;

    // Retry counter width and its saturation value.
    localparam int          RETRY_W   = 4;
    localparam logic [3:0]  RETRY_SAT = 4'hF;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } seq_state_t;

    // Output bundle, registered as a unit so every output changes on the
    // same edge as the state it belongs to.
    typedef struct packed {
        logic pll_rst;
        logic sys_reset;
        logic ready;
        logic fail;
    } seq_out_t;

    // Output values that belong to a given state.  Anything unknown is
    // treated as the safest configuration: everything held in reset.
    function automatic seq_out_t state_outputs(input seq_state_t st);
        seq_out_t o;
        o.pll_rst   = 1'b1;
        o.sys_reset = 1'b1;
        o.ready     = 1'b0;
        o.fail      = 1'b0;
        case (st)
            ST_PLL_RST: begin
                o.pll_rst   = 1'b1;
            end
            ST_WAIT_LOCK, ST_STABLE: begin
                o.pll_rst   = 1'b0;
            end
            ST_RUN: begin
                o.pll_rst   = 1'b0;
                o.sys_reset = 1'b0;
                o.ready     = 1'b1;
            end
            ST_FAIL: begin
                o.fail      = 1'b1;
            end
            default: begin
                o.pll_rst   = 1'b1;
            end
        endcase
        return o;
    endfunction

    // Largest of three cycle counts; sizes the shared cycle counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Saturating increment of the retry counter.
    function automatic logic [3:0] retry_step(input logic [3:0] cur);
        return (cur == RETRY_SAT) ? RETRY_SAT : cur + 4'd1;
    endfunction

endpackage : pll_reset_sequencer_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Generic two-flop synchronizer for bringing level signals into
//            the clk domain.  Both stages are cleared by the synchronous
//            reset so downstream logic sees a known value right after reset.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // First stage may go metastable; only the second stage is consumed.
    logic [WIDTH-1:0] meta;

    // Two back-to-back capture stages with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : sync_2ff
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer
// Purpose  : Drives the PLL reset, waits for a qualified lock and only then
//            releases the downstream system reset.  Lock timeouts trigger a
//            fresh PLL reset pulse up to MAX_RETRIES times before giving up
//            in FAIL.  Loss of lock while running re-enters the sequence.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = pll_reset_sequencer_pkg::DEF_PLL_RST_CYCLES,
    parameter int STABLE_CYCLES  = pll_reset_sequencer_pkg::DEF_STABLE_CYCLES,
    parameter int TIMEOUT_CYCLES = pll_reset_sequencer_pkg::DEF_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES    = pll_reset_sequencer_pkg::DEF_MAX_RETRIES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_count
);

    import pll_reset_sequencer_pkg::*;

    // One counter serves every timed state, so it is sized for the longest.
    localparam int CNT_MAX = max3(PLL_RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    // Terminal counts: the counter starts at zero on state entry, so the
    // last cycle of an N-cycle interval is count N-1.
    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    seq_state_t       state;
    seq_state_t       next_state;
    logic [CNT_W-1:0] cycle_cnt;
    logic             lock_s;
    logic             timeout_hit;
    logic             cnt_running;
    logic [3:0]       retry_next;
    seq_out_t         outs;

    // Raw lock is asynchronous; every decision below uses lock_s only.
    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_lock),
        .q     (lock_s)
    );

    assign retry_next = retry_step(retry_count);

    // Counter only advances in the timed states; RUN and FAIL hold it so it
    // can never wrap during a long run.
    assign cnt_running = (state == ST_PLL_RST) ||
                         (state == ST_WAIT_LOCK) ||
                         (state == ST_STABLE);

    // Next-state decision.  In WAIT_LOCK the lock test comes first so a lock
    // arriving on the timeout cycle wins and no retry is charged.
    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;
        case (state)
            ST_PLL_RST: begin
                if (cycle_cnt == PLL_RST_LAST) begin
                    next_state = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    next_state = ST_STABLE;
                end else if (cycle_cnt == TIMEOUT_LAST) begin
                    timeout_hit = 1'b1;
                    next_state  = (retry_next <= RETRY_LIMIT) ? ST_PLL_RST : ST_FAIL;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    next_state = ST_WAIT_LOCK;
                end else if (cycle_cnt == STABLE_LAST) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    next_state = ST_PLL_RST;
                end
            end
            ST_FAIL: begin
                next_state = ST_FAIL;
            end
            default: begin
                next_state = ST_PLL_RST;
            end
        endcase
    end

    // State, shared counter, retry count and the output bundle all update
    // together; outputs are derived from the state being entered so they
    // are registered and aligned with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_PLL_RST;
            cycle_cnt   <= '0;
            retry_count <= '0;
            outs        <= state_outputs(ST_PLL_RST);
        end else begin
            state <= next_state;
            outs  <= state_outputs(next_state);

            if (next_state != state) begin
                cycle_cnt <= '0;
            end else if (cnt_running) begin
                cycle_cnt <= cycle_cnt + CNT_ONE;
            end

            if (timeout_hit) begin
                retry_count <= retry_next;
            end
        end
    end

    assign pll_rst   = outs.pll_rst;
    assign sys_reset = outs.sys_reset;
    assign ready     = outs.ready;
    assign fail      = outs.fail;

endmodule : pll_reset_sequencer
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reset_sequencer
// Purpose  : Scoreboard bench for pll_reset_sequencer.  A stimulus process
//            drives pll_lock/reset and pushes the reference model's expected
//            outputs into a queue; a monitor pops and compares each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

    localparam int PRC = 4;
    localparam int SC  = 8;
    localparam int TO  = 32;
    localparam int MR  = 2;

    // Reference model phases.
    localparam int P_PULSE = 0;
    localparam int P_WAIT  = 1;
    localparam int P_QUAL  = 2;
    localparam int P_RUN   = 3;
    localparam int P_FAIL  = 4;

    logic       clk;
    logic       reset;
    logic       pll_lock;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic       fail;
    logic [3:0] retry_count;

    int n_cmp;
    int n_bad;

    logic [7:0] exp_q[$];

    // Reference model: phase, cycles spent in phase, retries, lock history.
    int   m_phase;
    int   m_spent;
    int   m_retries;
    logic m_hist1;
    logic m_hist2;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (PRC),
        .STABLE_CYCLES  (SC),
        .TIMEOUT_CYCLES (TO),
        .MAX_RETRIES    (MR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pll_lock    (pll_lock),
        .pll_rst     (pll_rst),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .fail        (fail),
        .retry_count (retry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic enter(input int ph);
        m_phase = ph;
        m_spent = 0;
    endtask

    // One clock edge of the specified behaviour.  'seen' is the lock value
    // that has travelled through two stages of synchronization.
    task automatic model_edge(input logic l, input logic r);
        logic seen;
        if (r) begin
            m_phase = P_PULSE; m_spent = 0; m_retries = 0;
            m_hist1 = 1'b0;    m_hist2 = 1'b0;
            return;
        end
        seen    = m_hist2;
        m_hist2 = m_hist1;
        m_hist1 = l;
        case (m_phase)
            P_PULSE: begin
                m_spent++;
                if (m_spent == PRC) enter(P_WAIT);
            end
            P_WAIT: begin
                if (seen) enter(P_QUAL);
                else begin
                    m_spent++;
                    if (m_spent == TO) begin
                        m_retries = (m_retries < 15) ? m_retries + 1 : 15;
                        enter((m_retries <= MR) ? P_PULSE : P_FAIL);
                    end
                end
            end
            P_QUAL: begin
                if (!seen) enter(P_WAIT);
                else begin
                    m_spent++;
                    if (m_spent == SC) enter(P_RUN);
                end
            end
            P_RUN: begin
                if (!seen) enter(P_PULSE);
            end
            default: ;
        endcase
    endtask

    function automatic logic [7:0] model_vec();
        logic [7:0] v;
        v[7]   = (m_phase == P_PULSE) || (m_phase == P_FAIL);
        v[6]   = (m_phase != P_RUN);
        v[5]   = (m_phase == P_RUN);
        v[4]   = (m_phase == P_FAIL);
        v[3:0] = 4'(m_retries);
        return v;
    endfunction

    // Drive one cycle of stimulus, advance the model, queue the expectation.
    task automatic step(input logic l, input logic r);
        pll_lock = l;
        reset    = r;
        @(posedge clk);
        model_edge(l, r);
        exp_q.push_back(model_vec());
        #1;
    endtask

    task automatic hold(input logic l, input int n);
        for (int i = 0; i < n; i++) step(l, 1'b0);
    endtask

    // Monitor: outputs are valid every cycle; compare on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [7:0] e;
            logic [7:0] a;
            e = exp_q.pop_front();
            a = {pll_rst, sys_reset, ready, fail, retry_count};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL outputs {pll_rst,sys_reset,ready,fail,retry}: got %b, expected %b (t=%0t)",
                         a, e, $time);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   falls;
        int   guard;
        int   saved_retries;
        logic prev_rst;

        n_cmp = 0; n_bad = 0;
        pll_lock = 1'b0; reset = 1'b1;
        m_phase = P_PULSE; m_spent = 0; m_retries = 0;
        m_hist1 = 1'b0; m_hist2 = 1'b0;

        // Reset state.
        step(1'b0, 1'b1);
        check("reset_pll_rst", pll_rst, 1);
        check("reset_sys_reset", sys_reset, 1);
        check("reset_ready_fail", {ready, fail}, 0);
        check("reset_retry", retry_count, 0);

        // Normal bring-up.
        hold(1'b0, 10);
        hold(1'b1, 30);
        check("bringup_ready", ready, 1);
        check("bringup_retry", retry_count, 0);

        // Lock bounce during qualification.
        step(1'b0, 1'b1);
        hold(1'b0, 6);
        hold(1'b1, 5);
        hold(1'b0, 3);
        hold(1'b1, 30);
        check("bounce_ready", ready, 1);
        check("bounce_retry", retry_count, 0);

        // Loss of lock while running.
        lat = 99;
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0);
            if (sys_reset && lat == 99) lat = i;
        end
        check("loss_latency_le3", (lat <= 3) ? 1 : 0, 1);
        check("loss_ready_low", ready, 0);
        hold(1'b1, 30);
        check("relock_ready", ready, 1);

        // Never locks: three PLL reset pulses, then FAIL.
        step(1'b0, 1'b1);
        prev_rst = pll_rst;
        falls = 0;
        guard = 0;
        while (m_phase != P_FAIL && guard < 400) begin
            step(1'b0, 1'b0);
            if (prev_rst && !pll_rst) falls++;
            prev_rst = pll_rst;
            guard++;
        end
        check("neverlock_bounded", (guard < 400) ? 1 : 0, 1);
        hold(1'b0, 5);
        check("neverlock_pulses", falls, 3);
        check("neverlock_fail", fail, 1);
        check("neverlock_retry", retry_count, 3);
        check("neverlock_rst_held", {pll_rst, sys_reset}, 3);

        // Reset out of FAIL.
        step(1'b0, 1'b1);
        check("failreset_fail", fail, 0);
        check("failreset_retry", retry_count, 0);
        check("failreset_pll_rst", pll_rst, 1);

        // Race: synchronized lock arrives on the exact timeout cycle.
        hold(1'b0, 2);
        guard = 0;
        while (!(m_phase == P_WAIT && m_spent == TO - 3) && guard < 200) begin
            step(1'b0, 1'b0);
            guard++;
        end
        check("race_bounded", (guard < 200) ? 1 : 0, 1);
        saved_retries = m_retries;
        hold(1'b1, 3);
        check("race_no_pll_rst", pll_rst, 0);
        check("race_retry", retry_count, saved_retries);
        hold(1'b1, 10);
        check("race_ready", ready, 1);

        // Reset asserted while running.
        step(1'b1, 1'b1);
        check("runreset_ready", ready, 0);

        // Randomized lock segments with occasional resets.
        for (int s = 0; s < 120; s++) begin
            if ($urandom_range(0, 24) == 0) begin
                step(1'b0, 1'b1);
            end else begin
                hold(1'($urandom_range(0, 1)), $urandom_range(1, 45));
            end
        end

        // Drain the scoreboard.
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pll_reset_sequencer
`default_nettype wire
